// File: rtl/serial_subtractor6bit.sv
// Bit-serial 6-bit subtractor: computes in1 - in2 - bin one bit per cycle, LSB first,
// through a single borrow register, with valid/ready handshakes on operand and result sides.
module serial_subtractor6bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in1,
  input  logic [5:0] in2,
  input  logic       bin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] diff,
  output logic       bout,
  output logic       zero,
  output logic       ovf,
  output logic [1:0] state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // The producer holds valid (and data) until that edge; ready never depends on valid.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [5:0] a_q, a_d;
  logic [5:0] b_q, b_d;
  logic [5:0] sr_q, sr_d;
  logic       br_q, br_d;
  logic [2:0] idx_q, idx_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [5:0] diff_q, diff_d;
  logic       bout_q, bout_d;
  logic       zero_q, zero_d;
  logic       ovf_q, ovf_d;

  logic d_bit;
  logic br_next;

  assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sr_d        = sr_q;
    br_d        = br_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = in1;
          b_d        = in2;
          br_d       = bin;
          idx_d      = 3'd0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[5:1]};
        b_d   = {1'b0, b_q[5:1]};
        sr_d  = {d_bit, sr_q[5:1]};
        br_d  = br_next;
        idx_d = idx_q + 3'd1;
        // Last bit: the operand bits still at position 0 are the original MSBs.
        if (idx_q == 3'd5) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          diff_d      = sr_d;
          bout_d      = br_next;
          zero_d      = (sr_d == 6'd0);
          ovf_d       = (a_q[0] != b_q[0]) && (d_bit != a_q[0]);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= 6'd0;
      b_q         <= 6'd0;
      sr_q        <= 6'd0;
      br_q        <= 1'b0;
      idx_q       <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= 6'd0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sr_q        <= sr_d;
      br_q        <= br_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_serial_subtractor6bit.sv
// Self-checking bench for serial_subtractor6bit: directed cases, backpressure,
// reset abort and a randomized back-to-back run against an arithmetic reference.
module tb_serial_subtractor6bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in1 = 6'd0;
  logic [5:0] in2 = 6'd0;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [5:0] diff;
  logic       bout;
  logic       zero;
  logic       ovf;
  logic [1:0] state_o;

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  serial_subtractor6bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf), .state_o(state_o)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference: {diff, bout, zero, ovf} from plain integer arithmetic.
  function automatic logic [8:0] model(input logic [5:0] a, input logic [5:0] b, input logic c);
    int r, sr;
    logic [5:0] d;
    logic bo, z, o;
    r  = int'(a) - int'(b) - int'(c);
    d  = r[5:0];
    bo = (r < 0);
    z  = (d == 6'd0);
    sr = int'($signed(a)) - int'($signed(b)) - int'(c);
    o  = (sr > 31) || (sr < -32);
    return {d, bo, z, o};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after the handshake.
  task automatic send(input logic [5:0] a, input logic [5:0] b, input logic c,
                      input bit push, output int hs_cyc);
    int w = 0;
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    in1 = a; in2 = b; bin = c; in_valid = 1'b1;
    if (push) exp_q.push_back(model(a, b, c));
    hs_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in1 = 6'($urandom); in2 = 6'($urandom); bin = 1'($urandom);
  endtask

  // Scoreboard side: waits out the latency, checks holds under backpressure, pops and compares.
  task automatic collect(input int hold, input bit chk_timing);
    logic [8:0] e;
    int w = 0;
    for (int i = 1; i <= 6; i++) begin
      if (chk_timing) begin
        check("busy_out_valid", 32'(out_valid), 32'd0);
        check("busy_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
    end
    check("latency_out_valid", 32'(out_valid), 32'd1);
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    for (int h = 0; h < hold; h++) begin
      check("bp_outputs", 32'({diff, bout, zero, ovf}), 32'(e));
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    check("result", 32'({diff, bout, zero, ovf}), 32'(e));
    check("done_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("exit_out_valid", 32'(out_valid), 32'd0);
    check("exit_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int hs, prev_hs;
    logic [5:0] ra, rb;
    logic rc;

    @(negedge clk);
    do_reset();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'({diff, bout, zero, ovf}), 32'd0);

    // Directed cases
    send(6'd13, 6'd5, 1'b0, 1'b1, hs);  collect(0, 1'b1);
    send(6'd5, 6'd13, 1'b0, 1'b1, hs);  collect(0, 1'b1);
    send(6'd0, 6'd0, 1'b1, 1'b1, hs);   collect(0, 1'b1);
    send(6'd21, 6'd21, 1'b0, 1'b1, hs); collect(0, 1'b1);
    send(6'd32, 6'd1, 1'b0, 1'b1, hs);  collect(0, 1'b1);
    send(6'd31, 6'd63, 1'b1, 1'b1, hs); collect(0, 1'b1);

    // Backpressure
    out_ready = 1'b0;
    send(6'd40, 6'd7, 1'b0, 1'b1, hs);
    collect(5, 1'b1);

    // Reset during RUN aborts the operation
    send(6'd50, 6'd3, 1'b0, 1'b0, hs);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("abort_no_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    send(6'd9, 6'd4, 1'b0, 1'b1, hs); collect(0, 1'b1);

    // Randomized back-to-back with out_ready held high
    prev_hs = 0;
    for (int n = 0; n < 1000; n++) begin
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, 1'b1, hs);
      if (n > 0) check("initiation_interval", 32'(hs - prev_hs), 32'd8);
      prev_hs = hs;
      collect(0, 1'b0);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
